// File: rtl/double_to_float_conv_if.sv
// Operand/result bundle for the binary64 -> binary32 convert unit.
// The controller drives rounding/double; the converter returns float and flags.
interface double_to_float_conv_if;
  logic [1:0]  rounding;
  logic [63:0] double;
  logic [31:0] float;
  logic        done;
  logic        nan_exception;
  logic        underflow_exception;
  logic        overflow_exception;

  modport master (
    output rounding,
    output double,
    input  float,
    input  done,
    input  nan_exception,
    input  underflow_exception,
    input  overflow_exception
  );

  modport slave (
    input  rounding,
    input  double,
    output float,
    output done,
    output nan_exception,
    output underflow_exception,
    output overflow_exception
  );
endinterface

// File: rtl/double_to_float_conv.sv
// binary64 -> binary32 format conversion with selectable rounding.
// One conversion per reset release: CAPTURE -> ALIGN -> ROUND -> DONE, result held until reset.
module double_to_float_conv (
  input  logic                         clk,
  input  logic                         reset,
  double_to_float_conv_if.slave        conv
);

  typedef enum logic [1:0] {StCapture, StAlign, StRound, StDone} state_e;
  typedef enum logic [1:0] {ClsFinite, ClsInf, ClsNan} cls_e;

  state_e      state_q;
  logic [63:0] dbl_q;
  logic [1:0]  rnd_q;

  // Aligned operand: biased binary32 exponent field (0 for tiny), 23 kept bits, guard, sticky.
  cls_e        cls_q;
  logic [11:0] e_q;
  logic [22:0] frac_q;
  logic        guard_q;
  logic        sticky_q;
  logic        tiny_q;

  // Align-stage combinational results
  cls_e        a_cls;
  logic [11:0] a_e;
  logic [22:0] a_frac;
  logic        a_guard;
  logic        a_sticky;
  logic        a_tiny;
  logic [10:0] exp64;
  logic [51:0] frac64;
  logic [52:0] sig;
  logic [11:0] e32;
  logic [11:0] sh;
  logic [75:0] wide;

  // Round-stage combinational results
  logic        sign;
  logic        inexact;
  logic        inc;
  logic        ovf;
  logic        ovf_to_inf;
  logic [34:0] sum;
  logic [31:0] r_float;
  logic        r_nan;
  logic        r_unf;
  logic        r_ovf;

  // Classify the captured operand, rebias, and denormalise tiny values into guard/sticky.
  always_comb begin
    exp64    = dbl_q[62:52];
    frac64   = dbl_q[51:0];
    sig      = {1'b1, frac64};
    e32      = {1'b0, exp64} - 12'd896;
    sh       = 12'd1 - e32;
    wide     = '0;
    a_cls    = ClsFinite;
    a_e      = '0;
    a_frac   = '0;
    a_guard  = 1'b0;
    a_sticky = 1'b0;
    a_tiny   = 1'b0;
    if (exp64 == 11'h7FF) begin
      a_cls = (frac64 == '0) ? ClsInf : ClsNan;
    end else if (exp64 == 11'h000) begin
      // Zero or binary64 subnormal: far below the binary32 range, all bits are sticky.
      a_sticky = |frac64;
      a_tiny   = 1'b1;
    end else if (!e32[11] && (e32 != 12'd0)) begin
      a_e      = e32;
      a_frac   = sig[51:29];
      a_guard  = sig[28];
      a_sticky = |sig[27:0];
    end else begin
      a_tiny = 1'b1;
      if (sh >= 12'd25) begin
        a_sticky = 1'b1;
      end else begin
        // Hidden bit lands below the 2^-126 position since the shift is at least one.
        wide     = 76'({sig, 24'b0} >> sh[4:0]);
        a_frac   = wide[75:53];
        a_guard  = wide[52];
        a_sticky = |wide[51:0];
      end
    end
  end

  // Round the aligned value; carries ripple naturally from fraction into exponent.
  always_comb begin
    sign    = dbl_q[63];
    inexact = guard_q | sticky_q;
    unique case (rnd_q)
      2'b00:   inc = guard_q & (sticky_q | frac_q[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = inexact & ~sign;
      default: inc = inexact & sign;
    endcase
    sum = {e_q, frac_q} + {34'b0, inc};
    ovf = (sum[34:23] >= 12'd255);
    unique case (rnd_q)
      2'b00:   ovf_to_inf = 1'b1;
      2'b01:   ovf_to_inf = 1'b0;
      2'b10:   ovf_to_inf = ~sign;
      default: ovf_to_inf = sign;
    endcase
    r_nan = 1'b0;
    r_unf = 1'b0;
    r_ovf = 1'b0;
    unique case (cls_q)
      ClsInf: r_float = {sign, 8'hFF, 23'h0};
      ClsNan: begin
        r_float = {sign, 8'hFF, 1'b1, dbl_q[50:29]};
        r_nan   = 1'b1;
      end
      default: begin
        if (ovf) begin
          r_ovf   = 1'b1;
          r_float = ovf_to_inf ? {sign, 8'hFF, 23'h0} : {sign, 8'hFE, 23'h7FFFFF};
        end else begin
          r_float = {sign, sum[30:0]};
        end
        r_unf = tiny_q & inexact;
      end
    endcase
  end

  // Conversion sequencer with registered result and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q                  <= StCapture;
      dbl_q                    <= '0;
      rnd_q                    <= '0;
      cls_q                    <= ClsFinite;
      e_q                      <= '0;
      frac_q                   <= '0;
      guard_q                  <= 1'b0;
      sticky_q                 <= 1'b0;
      tiny_q                   <= 1'b0;
      conv.float               <= '0;
      conv.done                <= 1'b0;
      conv.nan_exception       <= 1'b0;
      conv.underflow_exception <= 1'b0;
      conv.overflow_exception  <= 1'b0;
    end else begin
      unique case (state_q)
        StCapture: begin
          dbl_q   <= conv.double;
          rnd_q   <= conv.rounding;
          state_q <= StAlign;
        end
        StAlign: begin
          cls_q    <= a_cls;
          e_q      <= a_e;
          frac_q   <= a_frac;
          guard_q  <= a_guard;
          sticky_q <= a_sticky;
          tiny_q   <= a_tiny;
          state_q  <= StRound;
        end
        StRound: begin
          conv.float               <= r_float;
          conv.nan_exception       <= r_nan;
          conv.underflow_exception <= r_unf;
          conv.overflow_exception  <= r_ovf;
          conv.done                <= 1'b1;
          state_q                  <= StDone;
        end
        default: state_q <= StDone;
      endcase
    end
  end

endmodule

// File: tb/tb_double_to_float_conv.sv
// Randomised scoreboard bench for double_to_float_conv with a value/quantum reference model.
module tb_double_to_float_conv;

  typedef struct packed {
    logic [31:0] f;
    logic        nan;
    logic        unf;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  double_to_float_conv_if conv();

  double_to_float_conv dut (
    .clk   (clk),
    .reset (reset),
    .conv  (conv)
  );

  exp_t sb_q[$];
  int   vectors     = 0;
  int   checks      = 0;
  int   miscompares = 0;

  // Reference: value = m * 2^(e-1075); divide by the binary32 quantum, round the quotient.
  function automatic exp_t model(input logic [63:0] d, input logic [1:0] rnd);
    exp_t        r;
    logic        s, up, tiny, inexact, away;
    int          e64, e_unb, k, biased;
    logic [52:0] m;
    logic [63:0] n, rem, half;
    r   = '0;
    s   = d[63];
    e64 = int'(d[62:52]);
    if (e64 == 2047) begin
      if (d[51:0] == 52'd0) r.f = {s, 8'hFF, 23'h0};
      else begin
        r.f   = {s, 8'hFF, 1'b1, d[50:29]};
        r.nan = 1'b1;
      end
      return r;
    end
    if (e64 == 0) begin
      m     = {1'b0, d[51:0]};
      e_unb = -1023;
      k     = 925;
    end else begin
      m     = {1'b1, d[51:0]};
      e_unb = e64 - 1023;
      k     = (e_unb >= -126) ? 29 : 926 - e64;
    end
    tiny = (e_unb < -126);
    if (k >= 60) begin
      n    = 64'd0;
      rem  = {11'b0, m};
      half = 64'd1 << 62;
    end else begin
      n    = {11'b0, m} >> k;
      rem  = {11'b0, m} & ((64'd1 << k) - 64'd1);
      half = 64'd1 << (k - 1);
    end
    inexact = (rem != 64'd0);
    case (rnd)
      2'd0:    up = (rem > half) || ((rem == half) && n[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = inexact && !s;
      default: up = inexact && s;
    endcase
    n = n + 64'(up);
    if (tiny) begin
      r.f = {s, n[30:0]};
    end else begin
      biased = e_unb + 127;
      if (n == (64'd1 << 24)) begin
        biased = biased + 1;
        n      = n >> 1;
      end
      if (biased >= 255) begin
        r.ovf = 1'b1;
        away  = (rnd == 2'd0) || ((rnd == 2'd2) && !s) || ((rnd == 2'd3) && s);
        r.f   = away ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
      end else begin
        r.f = {s, biased[7:0], n[22:0]};
      end
    end
    r.unf = tiny && inexact;
    return r;
  endfunction

  function automatic logic [63:0] gen_operand();
    logic [63:0] rnd64;
    logic [51:0] frac;
    int          e;
    int          sel;
    rnd64 = {$urandom(), $urandom()};
    frac  = rnd64[51:0];
    sel   = $urandom_range(0, 11);
    case (sel)
      0:       e = 2047;
      1:       e = 0;
      2, 3:    e = $urandom_range(860, 897);
      4:       e = $urandom_range(1148, 2046);
      5: begin
        e    = $urandom_range(1149, 1150);
        frac = frac | 52'hF_FFFF_F000_0000;
      end
      6:       e = $urandom_range(1, 2046);
      default: e = $urandom_range(897, 1150);
    endcase
    case ($urandom_range(0, 5))
      0:       frac[28:0] = 29'h1000_0000;
      1:       frac[28:0] = 29'h0;
      2:       frac = (sel < 2) ? 52'd0 : frac;
      default: ;
    endcase
    return {rnd64[63], 11'(e), frac};
  endfunction

  // Monitor: pops the scoreboard on each rising done, sampled on the falling edge.
  initial begin
    exp_t got;
    exp_t expv;
    bit   seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!conv.done) seen = 1'b0;
      else if (!seen) begin
        seen = 1'b1;
        got  = {conv.float, conv.nan_exception, conv.underflow_exception,
                conv.overflow_exception};
        checks++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: got %h with no pending vector", got);
        end else begin
          expv = sb_q.pop_front();
          if (got !== expv) begin
            miscompares++;
            $display("FAIL result: got float=%h nan=%b unf=%b ovf=%b, want float=%h nan=%b unf=%b ovf=%b",
                     got.f, got.nan, got.unf, got.ovf, expv.f, expv.nan, expv.unf, expv.ovf);
          end
        end
      end
    end
  end

  task automatic check_cleared(input string name);
    checks++;
    if (conv.done !== 1'b0 || conv.float !== 32'h0 || conv.nan_exception !== 1'b0 ||
        conv.underflow_exception !== 1'b0 || conv.overflow_exception !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got done=%b float=%h flags=%b%b%b, want all zero", name, conv.done,
               conv.float, conv.nan_exception, conv.underflow_exception,
               conv.overflow_exception);
    end
  endtask

  // One conversion; inputs are scrambled after capture to show they are ignored.
  task automatic run(input logic [63:0] d, input logic [1:0] rnd, input exp_t expv,
                     input bit check_hold);
    int cyc;
    reset         = 1'b0;
    conv.double   = d;
    conv.rounding = rnd;
    sb_q.push_back(expv);
    vectors++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    conv.double   = {$urandom(), $urandom()};
    conv.rounding = 2'($urandom_range(0, 3));
    cyc = 1;
    while (!conv.done && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc != 3 || conv.done !== 1'b1) begin
      miscompares++;
      $display("FAIL latency: done=%b after %0d edges, want done=1 after 3", conv.done, cyc);
    end
    if (check_hold) begin
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (conv.done !== 1'b1 || conv.float !== expv.f) begin
        miscompares++;
        $display("FAIL hold: got done=%b float=%h, want done=1 float=%h", conv.done,
                 conv.float, expv.f);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // Abort after the given number of edges past release; outputs must clear at once.
  task automatic abort(input logic [63:0] d, input int edges, input string name);
    reset         = 1'b0;
    conv.double   = d;
    conv.rounding = 2'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (edges) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_cleared(name);
    @(posedge clk);
    #1;
    check_cleared(name);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] d;
    logic [1:0]  rnd;
    int          wait_cyc;
    reset         = 1'b1;
    conv.double   = '0;
    conv.rounding = '0;
    #2;
    reset = 1'b0;
    #1;
    check_cleared("reset_state");
    @(negedge clk);

    run(64'hFFF0000000000000, 2'd2, '{32'hFF800000, 1'b0, 1'b0, 1'b0}, 1'b1);
    run(64'hFFF4000000000000, 2'd2, '{32'hFFE00000, 1'b1, 1'b0, 1'b0}, 1'b0);
    run(64'h87F001FF00000000, 2'd2, '{32'h80000000, 1'b0, 1'b1, 1'b0}, 1'b0);
    run(64'hB7F001FF00000000, 2'd2, '{32'h802003FE, 1'b0, 1'b0, 1'b0}, 1'b0);
    run(64'hC000000000000004, 2'd2, '{32'hC0000000, 1'b0, 1'b0, 1'b0}, 1'b0);
    run(64'h40AD69C72B020C4A, 2'd2, '{32'h456B4E3A, 1'b0, 1'b0, 1'b0}, 1'b0);
    run(64'h40AD69C72B020C4A, 2'd1, '{32'h456B4E39, 1'b0, 1'b0, 1'b0}, 1'b0);
    run(64'h47F0000000000000, 2'd0, '{32'h7F800000, 1'b0, 1'b0, 1'b1}, 1'b1);
    run(64'h47F0000000000000, 2'd1, '{32'h7F7FFFFF, 1'b0, 1'b0, 1'b1}, 1'b0);
    run(64'h0000000000000001, 2'd2, '{32'h00000001, 1'b0, 1'b1, 1'b0}, 1'b0);
    run(64'h8000000000000000, 2'd3, '{32'h80000000, 1'b0, 1'b0, 1'b0}, 1'b0);

    abort(64'h40AD69C72B020C4A, 1, "abort_align");
    abort(64'h47F0000000000000, 2, "abort_round");

    for (int i = 0; i < 400; i++) begin
      d   = gen_operand();
      rnd = 2'($urandom_range(0, 3));
      run(d, rnd, model(d, rnd), (i % 50) == 0);
    end

    wait_cyc = 0;
    while (sb_q.size() != 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors never produced done, want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
